multicycle_control: RTL and testbench

Multicycle sequencer for the 3-bit-opcode processor datapath (add, addi, sw, lw, sll). Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives the datapath strobes one step per clock. Waits on a data-memory ready handshake and aborts stalled accesses with a watchdog. Keeps a count of retired instructions. Sits between the instruction register/PC logic and the register file, ALU and data memory, replacing single-cycle decoding.

---
 rtl/multicycle_pkg.sv | 27 ++
 rtl/multicycle_decode.sv | 21 ++
 rtl/multicycle_control.sv | 139 +++++++++++++
 tb/tb_multicycle_control.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - opcodes, state encoding and decode helpers for the multicycle sequencer
package multicycle_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // 001/010/011 are the only holes in the opcode map
    function automatic logic is_legal(input logic [2:0] op);
        return (op == OP_ADD) || op[2];
    endfunction

    function automatic logic is_mem(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/multicycle_decode.sv
// rtl/multicycle_decode.sv - combinational opcode classification for the latched instruction
module multicycle_decode
    import multicycle_pkg::*;
(
    input  logic [2:0] op,
    output logic       legal,
    output logic       mem,
    output logic       load,
    output logic       alu_src,
    output logic       alu_op
);

    always_comb begin
        legal   = is_legal(op);
        mem     = is_mem(op);
        load    = (op == OP_LW);
        alu_src = (op == OP_ADDI) || (op == OP_SW) || (op == OP_LW) || (op == OP_SLL);
        alu_op  = (op == OP_SLL);
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog and retire counter
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             alu_op,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemtoReg,
    output logic             instr_done,
    output logic             illegal,
    output logic             mem_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [WC_W-1:0]   wcnt_q;
    logic [CNT_W-1:0]  retired_q;

    logic dec_legal, dec_mem, dec_load, dec_alu_src, dec_alu_op;
    logic wait_hit;

    multicycle_decode u_decode (
        .op      (op_q),
        .legal   (dec_legal),
        .mem     (dec_mem),
        .load    (dec_load),
        .alu_src (dec_alu_src),
        .alu_op  (dec_alu_op)
    );

    // this stalled MEM cycle is the one that brings the wait count up to TIMEOUT
    assign wait_hit = (wcnt_q == WC_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        alu_op     = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            FETCH: begin
                if (run) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!dec_legal) begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ALUSrc  = dec_alu_src;
                alu_op  = dec_alu_op;
                state_d = dec_mem ? MEM : WB;
            end
            MEM: begin
                ALUSrc   = dec_alu_src;
                alu_op   = dec_alu_op;
                MemWrite = !dec_load;
                MemRead  = dec_load;
                // completion beats the watchdog when both land in the same cycle
                if (mem_ready) begin
                    if (dec_load) begin
                        state_d = WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                end else if (wait_hit) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end
            end
            WB: begin
                ALUSrc     = dec_alu_src;
                alu_op     = dec_alu_op;
                RegWrite   = 1'b1;
                MemtoReg   = dec_load;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            op_q      <= OP_ADD;
            wcnt_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && run) begin
                op_q <= opcode;
            end
            if (state_q == EXEC) begin
                wcnt_q <= '0;
            end else if (state_q == MEM && !mem_ready) begin
                wcnt_q <= wcnt_q + WC_W'(1);
            end
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    localparam int K_DONE = 0;
    localparam int K_ILL  = 1;
    localparam int K_ERR  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [2:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, IRWrite, RegWrite, ALUSrc, alu_op;
    logic             MemWrite, MemRead, MemtoReg;
    logic             instr_done, illegal, mem_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    typedef struct {
        int kind;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .alu_op     (alu_op),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .MemtoReg   (MemtoReg),
        .instr_done (instr_done),
        .illegal    (illegal),
        .mem_err    (mem_err),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {PCWrite, IRWrite, RegWrite, ALUSrc, alu_op, MemWrite, MemRead,
                MemtoReg, instr_done, illegal, mem_err};
    endfunction

    // advance one clock; inputs change 1ns after the edge, outputs are sampled 1ns later
    task automatic step(input logic r, input logic [2:0] op, input logic rdy);
        @(posedge clk);
        #1;
        run       = r;
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    // issue one instruction; lo = stalled MEM cycles before mem_ready rises
    task automatic do_instr(input string tag, input logic [2:0] op, input int lo,
                            input int kind, input int lat, input int e_memw,
                            input int e_memr, input int e_regw, input int e_mtr);
        exp_t e, got_e;
        int   cyc = 0;
        bit   got = 0;
        int   n_irw = 0, n_memw = 0, n_memr = 0, n_regw = 0, n_mtr = 0, n_alu_bad = 0;
        logic e_src, e_aop;
        case (op)
            3'b000:  begin e_src = 1'b0; e_aop = 1'b0; end
            3'b111:  begin e_src = 1'b1; e_aop = 1'b1; end
            default: begin e_src = 1'b1; e_aop = 1'b0; end
        endcase
        e.kind = kind;
        e.lat  = lat;
        sb.push_back(e);
        while (!got && cyc < 60) begin
            step(cyc == 0, op, (cyc >= 3 + lo));
            if (cyc == 0) chk({tag, ".fetch_state"}, 32'(state), 32'd0);
            n_irw  += int'(IRWrite && PCWrite);
            n_memw += int'(MemWrite);
            n_memr += int'(MemRead);
            n_regw += int'(RegWrite);
            n_mtr  += int'(MemtoReg);
            if (state >= 3'd2 && (ALUSrc !== e_src || alu_op !== e_aop)) n_alu_bad++;
            if (instr_done || illegal || mem_err) begin
                got   = 1;
                got_e = sb.pop_front();
                chk({tag, ".kind"}, 32'({instr_done, illegal, mem_err}),
                    got_e.kind == K_DONE ? 32'h4 : (got_e.kind == K_ILL ? 32'h2 : 32'h1));
                chk({tag, ".latency"}, 32'(cyc + 1), 32'(got_e.lat));
            end
            cyc++;
        end
        if (!got) begin
            chk({tag, ".no_event_in_budget"}, 32'(cyc), 32'(lat));
            void'(sb.pop_front());
        end
        chk({tag, ".irwrite_cycles"}, 32'(n_irw), 32'd1);
        chk({tag, ".memwrite_cycles"}, 32'(n_memw), 32'(e_memw));
        chk({tag, ".memread_cycles"}, 32'(n_memr), 32'(e_memr));
        chk({tag, ".regwrite_cycles"}, 32'(n_regw), 32'(e_regw));
        chk({tag, ".memtoreg_cycles"}, 32'(n_mtr), 32'(e_mtr));
        chk({tag, ".alu_ctrl_bad_cycles"}, 32'(n_alu_bad), 32'd0);
    endtask

    task automatic chk_retired(input string tag, input int exp);
        step(1'b0, 3'b000, 1'b0);
        chk(tag, 32'(retired), 32'(exp));
    endtask

    initial begin
        int idle_bad;
        rst       = 1'b1;
        run       = 1'b0;
        opcode    = 3'b000;
        mem_ready = 1'b0;
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.retired", 32'(retired), 32'd0);
        chk("reset.outputs", 32'(all_outs()), 32'd0);
        rst = 1'b0;

        // run low with a stray mem_ready: FETCH must idle without strobes
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b110, 1'b1);
            if (state !== 3'd0 || all_outs() !== 11'd0) idle_bad++;
        end
        chk("idle.run_low", 32'(idle_bad), 32'd0);
        chk("idle.retired", 32'(retired), 32'd0);

        do_instr("add", 3'b000, 0, K_DONE, 4, 0, 0, 1, 0);
        chk_retired("add.retired", 1);

        do_instr("lw_w2", 3'b110, 2, K_DONE, 7, 0, 3, 1, 1);
        chk_retired("lw_w2.retired", 2);

        do_instr("sw_w1", 3'b101, 1, K_DONE, 5, 2, 0, 0, 0);
        chk_retired("sw_w1.retired", 3);

        do_instr("sw_timeout", 3'b101, 1000, K_ERR, 3 + TIMEOUT, TIMEOUT, 0, 0, 0);
        chk_retired("sw_timeout.retired", 3);

        do_instr("sw_ready_at_limit", 3'b101, TIMEOUT - 1, K_DONE, 4 + TIMEOUT - 1,
                 TIMEOUT, 0, 0, 0);
        chk_retired("sw_ready_at_limit.retired", 4);

        do_instr("ill_010", 3'b010, 0, K_ILL, 2, 0, 0, 0, 0);
        do_instr("ill_001", 3'b001, 0, K_ILL, 2, 0, 0, 0, 0);
        do_instr("ill_011", 3'b011, 0, K_ILL, 2, 0, 0, 0, 0);
        chk_retired("illegal.retired", 4);

        do_instr("addi", 3'b100, 0, K_DONE, 4, 0, 0, 1, 0);
        chk_retired("addi.retired", 5);

        // reset lands while an LW is stalled in MEM
        step(1'b1, 3'b110, 1'b0);
        step(1'b0, 3'b110, 1'b0);
        step(1'b0, 3'b110, 1'b0);
        step(1'b0, 3'b110, 1'b0);
        chk("rst_mid.in_mem", 32'(state), 32'd3);
        chk("rst_mid.memread", 32'(MemRead), 32'd1);
        rst = 1'b1;
        step(1'b0, 3'b110, 1'b1);
        rst = 1'b0;
        chk("rst_mid.state", 32'(state), 32'd0);
        chk("rst_mid.outputs", 32'(all_outs()), 32'd0);
        chk("rst_mid.retired", 32'(retired), 32'd0);

        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            do_instr("preload_add", 3'b000, 0, K_DONE, 4, 0, 0, 1, 0);
        end
        chk_retired("preload.retired", (1 << CNT_W) - 1);

        do_instr("sll", 3'b111, 0, K_DONE, 4, 0, 0, 1, 0);
        chk_retired("sll.retired_wrap", 0);

        chk("scoreboard.empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
